// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, limits and address-width helper for regfile_mp
package regfile_pkg;
  localparam int MAX_NRD = 4;
  localparam int MAX_NWR = 2;
  typedef enum logic {INIT_ZERO, INIT_INDEX} rf_init_e;
  function automatic int aw_of(input int depth);
    return depth > 2 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: per-register write enable/data, highest write port wins; reg 0 writes dropped when ZERO_REG
module rf_wr_arb #(
  parameter int DW = 32,
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*DW-1:0]   wd,
  output logic [DEPTH-1:0]    reg_we,
  output logic [DEPTH*DW-1:0] reg_wd
);
  always_comb begin
    reg_we = '0;
    reg_wd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int w = 0; w < NWR; w++)
        if (we[w] && wa[w*AW +: AW] == AW'(i)) begin
          reg_we[i] = 1'b1;
          reg_wd[i*DW +: DW] = wd[w*DW +: DW];
        end
      if (ZERO_REG != 0 && i == 0) reg_we[i] = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, 1-cycle registered reads, async active-low reset.
// Define RF_BYPASS_EN to forward same-cycle write data to reads of the same register.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  parameter int INIT_IDX = 1,
  parameter int PROBE_IDX = 1,
  localparam int AW = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] wd,
  output logic [DW-1:0]     probe
);
  localparam rf_init_e INIT_MODE = INIT_IDX != 0 ? INIT_INDEX : INIT_ZERO;
  if (NRD > MAX_NRD || NWR > MAX_NWR) begin : g_bad_cfg
    $error("regfile_mp: port count exceeds supported maximum");
  end
  logic [DW-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]    reg_we;
  logic [DEPTH*DW-1:0] reg_wd;
  rf_wr_arb #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_arb (
    .we(we), .wa(wa), .wd(wd), .reg_we(reg_we), .reg_wd(reg_wd)
  );
  // reg 0 resets to 0 in either init mode, so the zero register never needs a separate reset
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_MODE == INIT_INDEX ? DW'(i) : '0;
    else
      for (int i = 0; i < DEPTH; i++) if (reg_we[i]) mem[i] <= reg_wd[i*DW +: DW];
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] val, q;
    assign a = ra[p*AW +: AW];
`ifdef RF_BYPASS_EN
    assign val = reg_we[a] ? reg_wd[a*DW +: DW] : mem[a];
`else
    assign val = mem[a];
`endif
    always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (re[p]) q <= val;
    assign rd[p*DW +: DW] = q;
  end
  assign probe = mem[PROBE_IDX];
endmodule
